fp_align_shift_ctrl: RTL
========================

// Module: fp_align_shift_ctrl
// PURPOSE
//  Alignment front-end for the half-precision FP adder. Sits directly upstream of UniversalBarrelShifter.
//  Unpacks two 16-bit operands and orders them by magnitude. Computes the exponent difference and drives
//  the shifter's data, shift-amount and direction inputs. 2-stage valid/ready pipeline, 1 op/cycle throughput.
// PARAMETERS
//  EXP_W    5   exponent field width
//  FRAC_W   10  fraction field width (hidden bit added internally)
//  DATA_W   16  shifter data width; requires DATA_W >= FRAC_W+1
//  SHAMT_W  4   shifter amount width; max shift = 2**SHAMT_W-1 = 15
// PORTS
//  clk           in   1       clock, rising edge
//  reset         in   1       asynchronous, active-high reset
//  InValid       in   1       operand pair valid
//  InReady       out  1       block can accept OpA/OpB this cycle
//  OpA           in   16      operand A {sign, exp[4:0], frac[9:0]}
//  OpB           in   16      operand B, same format
//  OutValid      out  1       aligned result valid
//  OutReady      in   1       downstream (shifter/adder) accepts result
//  BigSign       out  1       sign of larger-magnitude operand
//  BigExp        out  EXP_W   effective exponent of larger operand
//  BigMant       out  DATA_W  {hidden, frac, zero pad} of larger operand, MSB-aligned
//  SmallSign     out  1       sign of smaller operand
//  ShiftData     out  DATA_W  smaller mantissa, same packing as BigMant -> shifter A
//  ShiftAmt      out  SHAMT_W min(BigExp-SmallExp, 15) -> shifter Shift
//  ShiftChoice   out  1       constant SHIFT_RIGHT (1'b0) when OutValid
//  AlignOverflow out  1       exponent difference > 15; small operand is sticky-only
//  OpsSwapped    out  1       1 when B was the larger magnitude
//  Special       out  1       either operand has exp == all-ones (Inf/NaN)
// BEHAVIOUR
//  - Reset: both stage valids = 0; all outputs = 0; InReady = 1 after reset deasserts. In-flight ops are discarded.
//  - Handshake: transfer on InValid&&InReady and on OutValid&&OutReady. Outputs hold stable while OutValid&&!OutReady.
//  - s2_adv = !s2_valid || OutReady; s1_adv = !s1_valid || s2_adv; InReady = s1_adv (combinational, no skid buffer).
//  - Latency: accept at edge N -> OutValid at edge N+2 with OutReady high. No bubbles under continuous flow.
//  - Stall: OutReady low holds at most 2 ops; InReady falls when both stages are full. No op is lost or reordered.
//  - Stage 1 (unpack): hidden = (exp != 0); effective exp = (exp == 0) ? 1 : exp.
//    Mantissa = {hidden, frac, (DATA_W-FRAC_W-1) zeros}. Register fields and Special.
//  - Stage 2 (order/diff): compare {effExp, mant} unsigned. B strictly greater -> swap, OpsSwapped=1; tie keeps A.
//    diff = BigExp - SmallExp (unsigned, EXP_W bits).
//    If diff > 15: ShiftAmt = 15, AlignOverflow = 1; otherwise ShiftAmt = diff[3:0], AlignOverflow = 0.
//  - Special = 1 forces ShiftAmt = 0 and AlignOverflow = 0. Ordering still applies; the adder resolves Inf/NaN.
//  - Simultaneous accept and output in one cycle is legal at full rate. Reset dominates any handshake.
// STRUCTURE
//  - Shared package fp_half_pkg: EXP_W, FRAC_W, localparam EXP_MAX, SHIFT_RIGHT/SHIFT_LEFT codes,
//    and the unpacked-operand struct {sign, exp, mant}.
//  - Sub-module fp_half_unpack (combinational: field split, hidden bit, denormal exp fix).
//    Instantiated twice in stage 1. Ordering, diff and saturation logic stay in this module.
// TESTING
//  1. OpA=0x3C00 (1.0), OpB=0x3400 (0.25), OutReady=1 -> 2 cycles later: BigExp=15, BigMant=0x8000,
//     ShiftData=0x8000, ShiftAmt=2, OpsSwapped=0, AlignOverflow=0.
//  2. OpA=0x3400, OpB=0x3C00 -> same as 1 with OpsSwapped=1.
//  3. OpA=0x7800, OpB=0x0001 (denormal) -> BigExp=30, ShiftData=0x0020, ShiftAmt=15, AlignOverflow=1.
//  4. Stream 0x3C00/0x3800, 0x4000/0x3C00, 0x4400/0x3C00 with OutReady=0 for 4 cycles -> InReady=0 after 2 accepts.
//     After OutReady=1: results appear in order, ShiftAmt=1,1,2; none lost or duplicated.
//  5. OpA=0x7C00 (Inf), OpB=0x3C00 -> Special=1, ShiftAmt=0, BigExp=31.
//  6. reset=1 asynchronously with 2 ops in flight -> OutValid=0 immediately; no stale output after release.
//     Next op gives correct result at +2 cycles.

Source files
------------

// File: rtl/fp_half_pkg.sv
// Shared definitions for the half-precision FP datapath: field widths,
// shifter direction codes and the unpacked-operand record.
package fp_half_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;

    // Exponent field value reserved for Inf/NaN.
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    // Direction codes understood by the downstream barrel shifter.
    localparam logic SHIFT_RIGHT = 1'b0;
    localparam logic SHIFT_LEFT  = 1'b1;

    // Operand after unpacking: effective exponent and {hidden, frac}.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W:0]   mant;
    } half_op_t;

    // Map a "shift left" request onto the shifter's direction code.
    function automatic logic shift_dir_code(input logic left);
        return left ? SHIFT_LEFT : SHIFT_RIGHT;
    endfunction

endpackage

// File: rtl/fp_half_unpack.sv
// Combinational unpack of one half-precision operand: splits the fields,
// restores the hidden bit and gives denormals their effective exponent of 1.
module fp_half_unpack
    import fp_half_pkg::*;
(
    input  logic [EXP_W+FRAC_W:0] op,
    output half_op_t              unp,
    output logic                  special
);

    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;

    assign exp_f  = op[EXP_W+FRAC_W-1:FRAC_W];
    assign frac_f = op[FRAC_W-1:0];

    // Field split, hidden bit and denormal exponent fix-up.
    always_comb begin
        unp.sign = op[EXP_W+FRAC_W];
        unp.exp  = (exp_f == '0) ? EXP_W'(1) : exp_f;
        unp.mant = {(exp_f != '0), frac_f};
        special  = (exp_f == EXP_MAX);
    end

endmodule

// File: rtl/fp_align_shift_ctrl.sv
// Alignment front-end of the half-precision adder. Stage 1 unpacks both
// operands, stage 2 orders them by magnitude, forms the exponent difference
// and presents the smaller mantissa plus shift amount to the barrel shifter.
// EXP_W/FRAC_W must match fp_half_pkg, which sizes the unpack sub-module.
module fp_align_shift_ctrl #(
    parameter int EXP_W   = fp_half_pkg::EXP_W,
    parameter int FRAC_W  = fp_half_pkg::FRAC_W,
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [EXP_W+FRAC_W:0]  OpA,
    input  logic [EXP_W+FRAC_W:0]  OpB,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic                   BigSign,
    output logic [EXP_W-1:0]       BigExp,
    output logic [DATA_W-1:0]      BigMant,
    output logic                   SmallSign,
    output logic [DATA_W-1:0]      ShiftData,
    output logic [SHAMT_W-1:0]     ShiftAmt,
    output logic                   ShiftChoice,
    output logic                   AlignOverflow,
    output logic                   OpsSwapped,
    output logic                   Special
);

    import fp_half_pkg::*;

    localparam int SHIFT_MAX = (2 ** SHAMT_W) - 1;
    localparam int PAD_W     = DATA_W - FRAC_W - 1;

    // Saturate the exponent difference to the shifter range; returns
    // {overflow, amount}. Inf/NaN operands bypass alignment entirely.
    function automatic logic [SHAMT_W:0] sat_shift(input logic [EXP_W-1:0] d,
                                                   input logic force_zero);
        if (force_zero)
            return '0;
        if (int'(d) > SHIFT_MAX)
            return {1'b1, SHAMT_W'(SHIFT_MAX)};
        return {1'b0, SHAMT_W'(d)};
    endfunction

    // MSB-align {hidden, frac} inside the shifter data word.
    function automatic logic [DATA_W-1:0] pad_mant(input logic [FRAC_W:0] m);
        return DATA_W'(m) << PAD_W;
    endfunction

    logic s1_adv, s2_adv;
    logic ld_p1, ld_p2;

    half_op_t a_un, b_un;
    logic     a_special, b_special;

    logic     vld_p1;
    half_op_t a_p1, b_p1;
    logic     special_p1;

    logic              b_gt;
    half_op_t          big_op, small_op;
    logic [EXP_W-1:0]  exp_diff;
    logic [SHAMT_W:0]  sat_res;

    logic              vld_p2;
    logic              big_sign_p2;
    logic [EXP_W-1:0]  big_exp_p2;
    logic [DATA_W-1:0] big_mant_p2;
    logic              small_sign_p2;
    logic [DATA_W-1:0] small_mant_p2;
    logic [SHAMT_W-1:0] shamt_p2;
    logic              ovf_p2;
    logic              swap_p2;
    logic              special_p2;

    // Pipeline advance: a stage moves when it is empty or its consumer moves.
    assign s2_adv  = !vld_p2 || OutReady;
    assign s1_adv  = !vld_p1 || s2_adv;
    assign InReady = s1_adv;
    assign ld_p1   = s1_adv && InValid;
    assign ld_p2   = s2_adv && vld_p1;

    // ---- stage 1: unpack ----
    fp_half_unpack u_unpack_a (
        .op      (OpA),
        .unp     (a_un),
        .special (a_special)
    );

    fp_half_unpack u_unpack_b (
        .op      (OpB),
        .unp     (b_un),
        .special (b_special)
    );

    // Stage-1 occupancy; reset discards anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vld_p1 <= 1'b0;
        else if (s1_adv)
            vld_p1 <= InValid;
    end

    // Stage-1 operand registers, loaded only on an accepted transfer.
    always_ff @(posedge clk) begin
        if (ld_p1) begin
            a_p1       <= a_un;
            b_p1       <= b_un;
            special_p1 <= a_special || b_special;
        end
    end

    // ---- stage 2: order, difference, saturation ----
    // B must be strictly larger to swap, so equal magnitudes keep A as big.
    always_comb begin
        b_gt     = {b_p1.exp, b_p1.mant} > {a_p1.exp, a_p1.mant};
        big_op   = b_gt ? b_p1 : a_p1;
        small_op = b_gt ? a_p1 : b_p1;
        exp_diff = big_op.exp - small_op.exp;
        sat_res  = sat_shift(exp_diff, special_p1);
    end

    // Stage-2 occupancy; holds while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vld_p2 <= 1'b0;
        else if (s2_adv)
            vld_p2 <= vld_p1;
    end

    // Stage-2 result registers, frozen while OutValid && !OutReady.
    always_ff @(posedge clk) begin
        if (ld_p2) begin
            big_sign_p2   <= big_op.sign;
            big_exp_p2    <= big_op.exp;
            big_mant_p2   <= pad_mant(big_op.mant);
            small_sign_p2 <= small_op.sign;
            small_mant_p2 <= pad_mant(small_op.mant);
            shamt_p2      <= sat_res[SHAMT_W-1:0];
            ovf_p2        <= sat_res[SHAMT_W];
            swap_p2       <= b_gt;
            special_p2    <= special_p1;
        end
    end

    // ---- output: result bus is zero whenever no valid result is held ----
    assign OutValid      = vld_p2;
    assign BigSign       = vld_p2 && big_sign_p2;
    assign BigExp        = vld_p2 ? big_exp_p2    : '0;
    assign BigMant       = vld_p2 ? big_mant_p2   : '0;
    assign SmallSign     = vld_p2 && small_sign_p2;
    assign ShiftData     = vld_p2 ? small_mant_p2 : '0;
    assign ShiftAmt      = vld_p2 ? shamt_p2      : '0;
    assign ShiftChoice   = vld_p2 && shift_dir_code(1'b0);
    assign AlignOverflow = vld_p2 && ovf_p2;
    assign OpsSwapped    = vld_p2 && swap_p2;
    assign Special       = vld_p2 && special_p2;

endmodule
